// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: in-order fetch responses after a fixed latency,
// backed by a word store that is loaded through a side write port.
module instr_mem_responder #(
    parameter logic [31:0] MEM_BASE        = 32'h0000_0000,
    parameter int unsigned MEM_WORDS       = 4096,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_error_o,
    input  logic        load_we_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i,
    output logic [31:0] err_count_o
);
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int NW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [32:0]   SPAN    = 33'(MEM_WORDS) * 33'd4;
    localparam logic [CW-1:0] CD_INIT = CW'(LATENCY - 1);
    localparam logic [NW-1:0] CNT_MAX = NW'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [31:0]   data;
        logic          err;
        logic [CW-1:0] cd;
    } entry_t;

    logic [31:0] mem [MEM_WORDS];

    entry_t                     q [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] vld;
    logic [PW-1:0]              head, tail;
    logic [NW-1:0]              cnt;
    logic [31:0]                err_cnt;

    logic [31:0] req_off, ld_addr, ld_off;
    logic        req_in_range, req_err, ld_in_range;
    logic        accept, deliver;
    logic [31:0] rd_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Range checks are done in 33 bits so a store ending at 4 GiB cannot wrap.
    assign req_off      = req_addr_i - MEM_BASE;
    assign req_in_range = (req_addr_i >= MEM_BASE) && ({1'b0, req_off} < SPAN);
    assign req_err      = (req_addr_i[1:0] != 2'b00) || !req_in_range;

    assign ld_addr     = {load_addr_i[31:2], 2'b00};
    assign ld_off      = ld_addr - MEM_BASE;
    assign ld_in_range = (ld_addr >= MEM_BASE) && ({1'b0, ld_off} < SPAN);

    logic unused_bits;
    assign unused_bits = ^{req_off[31:AW+2], req_off[1:0], ld_off[31:AW+2], ld_off[1:0],
                           load_addr_i[1:0]};

    assign rd_data = mem[req_off[AW+1:2]];

    assign req_ready_o = (cnt < CNT_MAX);
    assign rsp_valid_o = vld[head] && (q[head].cd == '0);
    assign rsp_data_o  = rsp_valid_o ? q[head].data : '0;
    assign rsp_error_o = rsp_valid_o ? q[head].err  : 1'b0;
    assign err_count_o = err_cnt;

    assign accept  = req_valid_i && req_ready_o;
    assign deliver = rsp_valid_o && rsp_ready_i;

    // Store is deliberately outside the reset domain; the async read above
    // sees the pre-edge contents, giving read-before-write on collisions.
    always_ff @(posedge clk_i) begin
        if (load_we_i && ld_in_range) mem[ld_off[AW+1:2]] <= load_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) q[i] <= '0;
            vld     <= '0;
            head    <= '0;
            tail    <= '0;
            cnt     <= '0;
            err_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                if (vld[i] && q[i].cd != '0) q[i].cd <= q[i].cd - 1'b1;
            end
            if (deliver) begin
                vld[head] <= 1'b0;
                head      <= ptr_inc(head);
                if (rsp_error_o && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
            // A free tail slot never aliases the head while entries are pending.
            if (accept) begin
                q[tail]   <= '{data: req_err ? 32'h0 : rd_data, err: req_err, cd: CD_INIT};
                vld[tail] <= 1'b1;
                tail      <= ptr_inc(tail);
            end
            case ({accept, deliver})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: directed scenarios plus random traffic, all
// checked every cycle against a timestamp-based queue model of the responder.
module tb_instr_mem_responder;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned WORDS = 64;
    localparam int unsigned LAT   = 2;
    localparam int unsigned MAXO  = 4;

    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        req_valid_i = 1'b0, req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic        rsp_valid_o, rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic        rsp_error_o;
    logic        load_we_i = 1'b0;
    logic [31:0] load_addr_i = '0, load_data_i = '0;
    logic [31:0] err_count_o;

    instr_mem_responder #(.MEM_BASE(BASE), .MEM_WORDS(WORDS), .LATENCY(LAT),
                          .MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
        .rsp_error_o(rsp_error_o), .load_we_i(load_we_i), .load_addr_i(load_addr_i),
        .load_data_i(load_data_i), .err_count_o(err_count_o));

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each response carries the cycle index at which it becomes presentable.
    typedef struct { logic [31:0] d; logic e; longint rdy; } rsp_t;
    rsp_t        mq[$];
    logic [31:0] smem [WORDS];
    logic [31:0] m_err = '0;
    longint      cyc = 0;

    function automatic logic addr_ok(input logic [31:0] a);
        longint la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * longint'(WORDS));
    endfunction

    always @(negedge clk_i) begin
        logic exp_rdy, exp_vld;
        rsp_t r;
        if (!rst_ni) begin
            mq.delete();
            m_err = '0;
        end
        exp_rdy = (mq.size() < MAXO);
        exp_vld = (mq.size() > 0) && (cyc >= mq[0].rdy);
        chk("req_ready", {31'b0, req_ready_o}, {31'b0, exp_rdy});
        chk("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, exp_vld});
        chk("rsp_data",  rsp_data_o, exp_vld ? mq[0].d : 32'h0);
        chk("rsp_error", {31'b0, rsp_error_o}, {31'b0, exp_vld ? mq[0].e : 1'b0});
        chk("err_count", err_count_o, m_err);
        if (rst_ni) begin
            if (exp_vld && rsp_ready_i) begin
                if (mq[0].e && m_err != 32'hFFFF_FFFF) m_err++;
                void'(mq.pop_front());
            end
            if (req_valid_i && exp_rdy) begin
                r.e   = (req_addr_i[1:0] != 2'b00) || !addr_ok(req_addr_i);
                r.d   = r.e ? 32'h0 : smem[(req_addr_i - BASE) >> 2];
                r.rdy = cyc + LAT;
                mq.push_back(r);
            end
        end
        if (load_we_i && addr_ok({load_addr_i[31:2], 2'b00}))
            smem[({load_addr_i[31:2], 2'b00} - BASE) >> 2] = load_data_i;
        cyc++;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic req(input logic [31:0] a);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        step();
        req_valid_i = 1'b0;
    endtask

    initial begin
        steps(2);
        rst_ni = 1'b1;
        step();

        for (int i = 0; i < int'(WORDS); i++) begin
            load_we_i   = 1'b1;
            load_addr_i = BASE + 32'(i * 4);
            load_data_i = (i == 0) ? 32'h0000_0013 : (i == 4) ? 32'h1111_1111 : $urandom;
            step();
        end
        load_we_i = 1'b0;

        // T1: single fetch, latency 2
        rsp_ready_i = 1'b1;
        req(BASE);
        @(negedge clk_i); chk("t1_not_early", {31'b0, rsp_valid_o}, 32'd0);
        step();
        @(negedge clk_i);
        chk("t1_valid", {31'b0, rsp_valid_o}, 32'd1);
        chk("t1_data", rsp_data_o, 32'h0000_0013);
        chk("t1_err", {31'b0, rsp_error_o}, 32'd0);
        steps(2);

        // T3: misaligned and just-past-the-end requests
        req(BASE + 32'h2);
        req(BASE + 4 * WORDS);
        steps(4);
        @(negedge clk_i); chk("t3_errcnt", err_count_o, 32'd2);

        // T4: load and fetch of the same word in one cycle
        load_we_i = 1'b1; load_addr_i = BASE + 32'h10; load_data_i = 32'hDEAD_BEEF;
        req_valid_i = 1'b1; req_addr_i = BASE + 32'h10;
        step();
        load_we_i = 1'b0; req_valid_i = 1'b0;
        step();
        @(negedge clk_i); chk("t4_old", rsp_data_o, 32'h1111_1111);
        step();
        req(BASE + 32'h10);
        step();
        @(negedge clk_i); chk("t4_new", rsp_data_o, 32'hDEAD_BEEF);
        step();

        // T2/T5: fill the queue with rsp_ready low, hold, then drain
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_addr_i = BASE + 32'(i * 4);
            step();
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk("t2_full", {31'b0, req_ready_o}, 32'd0);
            chk("t5_hold_data", rsp_data_o, 32'h0000_0013);
            chk("t5_hold_valid", {31'b0, rsp_valid_o}, 32'd1);
            step();
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i); chk("t2_no_early_ready", {31'b0, req_ready_o}, 32'd0);
        step();
        @(negedge clk_i); chk("t2_ready_reopen", {31'b0, req_ready_o}, 32'd1);
        step();
        req_valid_i = 1'b0;
        steps(8);

        // T6: reset with three requests in flight
        rsp_ready_i = 1'b0;
        req(BASE + 32'h4); req(BASE + 32'h8); req(BASE + 32'hC);
        #2 rst_ni = 1'b0;
        #1 chk("t6_async_valid", {31'b0, rsp_valid_o}, 32'd0);
        steps(2);
        rst_ni = 1'b1;
        rsp_ready_i = 1'b1;
        steps(6);
        @(negedge clk_i); chk("t6_no_stale", {31'b0, rsp_valid_o}, 32'd0);
        step();

        // Random traffic with loads, faults and backpressure
        for (int n = 0; n < 600; n++) begin
            int unsigned k;
            k = $urandom_range(0, 9);
            req_valid_i = ($urandom_range(0, 9) < 7);
            case (k)
                0:       req_addr_i = BASE + 32'($urandom_range(0, WORDS - 1) * 4 + $urandom_range(1, 3));
                1:       req_addr_i = BASE + 4 * WORDS + 32'($urandom_range(0, 15) * 4);
                default: req_addr_i = BASE + 32'($urandom_range(0, WORDS - 1) * 4);
            endcase
            rsp_ready_i = ($urandom_range(0, 9) < 6);
            load_we_i   = ($urandom_range(0, 9) < 2);
            load_addr_i = BASE + 32'($urandom_range(0, WORDS + 7) * 4 + $urandom_range(0, 3));
            load_data_i = $urandom;
            step();
        end
        req_valid_i = 1'b0; load_we_i = 1'b0; rsp_ready_i = 1'b1;
        steps(10);
        @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
